// File: rtl/apb_slave_regbank_if.sv
// APB completer bus bundle: bridge-driven request signals plus completer response.
interface apb_slave_regbank_if;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  modport slave  (input  Pselx, Penable, Pwrite, Paddr, Pwdata,
                  output Prdata, Pready, Pslverr);
  modport master (output Pselx, Penable, Pwrite, Paddr, Pwdata,
                  input  Prdata, Pready, Pslverr);
endinterface

// File: rtl/apb_slave_regbank.sv
// APB completer with eight 32-bit registers, programmable wait states and range errors.
// Optional APB_SLV_IRQ_EN: reg6 = irq mask, reg7 = W1C status, adds registered irq output.
module apb_slave_regbank #(
  parameter int unsigned SEL_INDEX   = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5A5_5A5A
) (
  input  logic Hclk,
  input  logic Hreset,
  apb_slave_regbank_if.slave bus
`ifdef APB_SLV_IRQ_EN
  ,
  output logic irq
`endif
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:2] addr_q;
  logic        wr_q;
  logic [31:0] wdata_q;
  logic [31:0] regs_q [8];
  logic [31:0] regs_d [8];

  logic        sel, cap, ready, hit, err, commit;
  logic [2:0]  idx;
  logic [31:0] rdval;

  assign sel = bus.Pselx[SEL_INDEX];
  assign idx = addr_q[4:2];
  assign hit = (addr_q[31:5] == BASE_ADDR[31:5]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel && !bus.Penable) begin
          cap     = 1'b1;
          cnt_d   = 4'(WAIT_STATES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!sel) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (bus.Penable) begin
          ready   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err    = ready && (!hit || (wr_q && idx == 3'd0));
  assign commit = ready && wr_q && !err;
  assign rdval  = (idx == 3'd0) ? ID_VALUE : regs_q[idx];

  assign bus.Pready  = ready;
  assign bus.Pslverr = err;
  assign bus.Prdata  = (ready && !wr_q && !err) ? rdval : 32'h0;

  always_comb begin
    for (int i = 0; i < 8; i++) regs_d[i] = regs_q[i];
    if (commit) regs_d[idx] = wdata_q;
`ifdef APB_SLV_IRQ_EN
    // Status bits are set by writes to regs 1..5; reg7 writes clear, and set wins.
    regs_d[7] = (regs_q[7] & ~((commit && idx == 3'd7) ? wdata_q : 32'h0))
              | ((commit && idx >= 3'd1 && idx <= 3'd5) ? (32'h1 << (idx - 3'd1)) : 32'h0);
`endif
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= 32'h0;
      for (int i = 0; i < 8; i++) regs_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        addr_q  <= bus.Paddr[31:2];
        wr_q    <= bus.Pwrite;
        wdata_q <= bus.Pwdata;
      end
      for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
    end
  end

`ifdef APB_SLV_IRQ_EN
  logic irq_q;
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) irq_q <= 1'b0;
    else        irq_q <= |(regs_d[6] & regs_d[7]);
  end
  assign irq = irq_q;
`else
  logic unused_bus;
  assign unused_bus = ^bus.Paddr[1:0];
`endif

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench: three completers (0/3/2 wait states) sharing one APB bus, one per Pselx bit.
module tb_apb_slave_regbank;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic [2:0]  pselx = 3'b000;
  logic        penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = 32'h0, pwdata = 32'h0;
  int          passed = 0, total = 0;

  always #5 hclk = ~hclk;

  apb_slave_regbank_if bus0 ();
  apb_slave_regbank_if bus1 ();
  apb_slave_regbank_if bus2 ();

  assign bus0.Pselx = pselx;  assign bus1.Pselx = pselx;  assign bus2.Pselx = pselx;
  assign bus0.Penable = penable; assign bus1.Penable = penable; assign bus2.Penable = penable;
  assign bus0.Pwrite = pwrite; assign bus1.Pwrite = pwrite; assign bus2.Pwrite = pwrite;
  assign bus0.Paddr = paddr;  assign bus1.Paddr = paddr;  assign bus2.Paddr = paddr;
  assign bus0.Pwdata = pwdata; assign bus1.Pwdata = pwdata; assign bus2.Pwdata = pwdata;

`ifdef APB_SLV_IRQ_EN
  logic irq0, irq1, irq2;
`endif

  apb_slave_regbank #(.SEL_INDEX(0), .BASE_ADDR(BASE), .WAIT_STATES(0)) u0 (
    .Hclk(hclk), .Hreset(hreset), .bus(bus0)
`ifdef APB_SLV_IRQ_EN
    , .irq(irq0)
`endif
  );
  apb_slave_regbank #(.SEL_INDEX(1), .BASE_ADDR(BASE), .WAIT_STATES(3)) u1 (
    .Hclk(hclk), .Hreset(hreset), .bus(bus1)
`ifdef APB_SLV_IRQ_EN
    , .irq(irq1)
`endif
  );
  apb_slave_regbank #(.SEL_INDEX(2), .BASE_ADDR(BASE), .WAIT_STATES(2)) u2 (
    .Hclk(hclk), .Hreset(hreset), .bus(bus2)
`ifdef APB_SLV_IRQ_EN
    , .irq(irq2)
`endif
  );

  logic [2:0]  rdy_v, err_v;
  logic [31:0] rd_v [3];
  assign rdy_v = {bus2.Pready, bus1.Pready, bus0.Pready};
  assign err_v = {bus2.Pslverr, bus1.Pslverr, bus0.Pslverr};
  assign rd_v[0] = bus0.Prdata;
  assign rd_v[1] = bus1.Prdata;
  assign rd_v[2] = bus2.Prdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One APB transfer to completer s; scramble alters the bus during the access phase.
  task automatic xfer(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic scramble, output logic [31:0] rd, output logic er,
                      output int waits);
    @(posedge hclk); #1;
    pselx = 3'(1 << s); penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(posedge hclk); #1;
    penable = 1'b1;
    if (scramble) begin paddr = a ^ 32'h4; pwdata = ~d; end
    waits = 0;
    rd = 32'hx; er = 1'bx;
    forever begin
      @(negedge hclk);
      if (rdy_v[s]) begin rd = rd_v[s]; er = err_v[s]; break; end
      waits++;
      if (waits > 40) begin
        total++;
        $error("FAIL timeout: observed no Pready expected Pready within 40 cycles");
        break;
      end
    end
    @(posedge hclk); #1;
    pselx = 3'b000; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          wt;

  initial begin
    // Reset state
    #12;
    check("rst_rdy", {29'h0, rdy_v}, 32'h0);
    check("rst_err", {29'h0, err_v}, 32'h0);
    check("rst_rd0", rd_v[0], 32'h0);
    check("rst_rd1", rd_v[1], 32'h0);
    @(posedge hclk); #1; hreset = 1'b0;

    // ID read with no wait states
    xfer(0, 1'b0, BASE, 32'h0, 1'b0, rd, er, wt);
    check("id_rd", rd, 32'hA5A5_5A5A);
    check("id_err", {31'h0, er}, 32'h0);
    check("id_waits", wt, 0);

    // Write/readback reg1
    xfer(0, 1'b1, BASE + 32'h4, 32'hDEAD_BEEF, 1'b0, rd, er, wt);
    check("wr1_err", {31'h0, er}, 32'h0);
    check("wr1_rd", rd, 32'h0);
    xfer(0, 1'b0, BASE + 32'h4, 32'h0, 1'b0, rd, er, wt);
    check("rd1", rd, 32'hDEAD_BEEF);
    check("rd1_err", {31'h0, er}, 32'h0);

    // Three wait states, bus scrambled during the wait
    xfer(1, 1'b1, BASE + 32'h8, 32'h1234_5678, 1'b1, rd, er, wt);
    check("ws3_wr_waits", wt, 3);
    check("ws3_wr_err", {31'h0, er}, 32'h0);
    xfer(1, 1'b0, BASE + 32'h8, 32'h0, 1'b0, rd, er, wt);
    check("ws3_rd", rd, 32'h1234_5678);
    check("ws3_rd_waits", wt, 3);
    xfer(1, 1'b0, BASE + 32'hC, 32'h0, 1'b0, rd, er, wt);
    check("ws3_rd3", rd, 32'h0);

    // Errors: write to reg0, out-of-window read
    xfer(0, 1'b1, BASE, 32'hFFFF_FFFF, 1'b0, rd, er, wt);
    check("wr0_err", {31'h0, er}, 32'h1);
    xfer(0, 1'b0, BASE, 32'h0, 1'b0, rd, er, wt);
    check("rd0_keep", rd, 32'hA5A5_5A5A);
    check("rd0_err", {31'h0, er}, 32'h0);
    xfer(0, 1'b0, BASE + 32'h40, 32'h0, 1'b0, rd, er, wt);
    check("miss_err", {31'h0, er}, 32'h1);
    check("miss_rd", rd, 32'h0);
    xfer(0, 1'b1, BASE + 32'h44, 32'h5555_5555, 1'b0, rd, er, wt);
    check("miss_wr_err", {31'h0, er}, 32'h1);
    xfer(0, 1'b0, BASE + 32'h4, 32'h0, 1'b0, rd, er, wt);
    check("miss_wr_noalias", rd, 32'hDEAD_BEEF);

    // Abort on DUT with two wait states
    @(posedge hclk); #1;
    pselx = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'hC; pwdata = 32'h1111_1111;
    @(posedge hclk); #1; penable = 1'b1;
    @(posedge hclk); #1; pselx = 3'b000; penable = 1'b0;
    @(negedge hclk);
    check("abort_rdy", {31'h0, bus2.Pready}, 32'h0);
    xfer(2, 1'b0, BASE + 32'hC, 32'h0, 1'b0, rd, er, wt);
    check("abort_reg3", rd, 32'h0);
    check("ws2_waits", wt, 2);

    // Reset mid-access
    @(posedge hclk); #1;
    pselx = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'hC; pwdata = 32'h2222_2222;
    @(posedge hclk); #1; penable = 1'b1;
    @(posedge hclk); #1; hreset = 1'b1; pselx = 3'b000; penable = 1'b0;
    #1;
    check("rstmid_rdy", {29'h0, rdy_v}, 32'h0);
    check("rstmid_rd2", rd_v[2], 32'h0);
    @(posedge hclk); #1; hreset = 1'b0;
    xfer(2, 1'b0, BASE + 32'hC, 32'h0, 1'b0, rd, er, wt);
    check("rstmid_reg3", rd, 32'h0);
    xfer(0, 1'b0, BASE + 32'h4, 32'h0, 1'b0, rd, er, wt);
    check("rstmid_reg1_cleared", rd, 32'h0);

`ifdef APB_SLV_IRQ_EN
    check("irq_rst", {31'h0, irq0}, 32'h0);
    xfer(0, 1'b1, BASE + 32'h18, 32'h1, 1'b0, rd, er, wt);
    check("irq_mask_only", {31'h0, irq0}, 32'h0);
    xfer(0, 1'b1, BASE + 32'h4, 32'h77, 1'b0, rd, er, wt);
    check("irq_set", {31'h0, irq0}, 32'h1);
    xfer(0, 1'b0, BASE + 32'h1C, 32'h0, 1'b0, rd, er, wt);
    check("irq_status", rd, 32'h1);
    xfer(0, 1'b1, BASE + 32'h1C, 32'h1, 1'b0, rd, er, wt);
    check("irq_clr", {31'h0, irq0}, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
